alu_mp_sequencer: RTL

Multi-precision operation sequencer: the initiator side of the 16-bit ALU port set (carry_in, in_a, in_b, select, mode → alu_out, carry_out, compare). It accepts a WORDS×16-bit operation over a valid/ready request channel and drives the combinational ALU one 16-bit slice per cycle, LSB first. In arithmetic mode it chains carry_out into the next slice's carry_in. It collects the slices into a wide result returned on a valid/ready response channel, and sits between the datapath control and the ALU instance in the parent.

---
 rtl/alu_mp_sequencer_pkg.sv | 18 +
 rtl/alu_mp_sequencer_if.sv | 40 ++++
 rtl/alu_mp_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_mp_sequencer_pkg.sv
// Shared definitions for the multi-precision ALU sequencer.
//   DATA_W      : ALU slice width (fixed at 16)
//   state_t     : sequencer FSM states
//   MODE_ARITH / MODE_LOGIC : encodings of the ALU mode bit
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// Request/response channels of the multi-precision ALU sequencer.
//   req_* : valid/ready operation request (operands, select, mode, carry-in)
//   rsp_* : valid/ready result (wide data, final carry, accumulated compare)
// master modport: the requester side; slave modport: the sequencer.
interface alu_mp_sequencer_if #(
  parameter int unsigned WORDS = 4
);
  import alu_seq_pkg::*;

  localparam int unsigned VEC_W = WORDS * DATA_W;

  logic             req_valid;
  logic             req_ready;
  logic [VEC_W-1:0] req_a;
  logic [VEC_W-1:0] req_b;
  logic [3:0]       req_select;
  logic             req_mode;
  logic             req_carry_in;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [VEC_W-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_compare;

  modport master (
    output req_valid, req_a, req_b, req_select, req_mode, req_carry_in,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_carry, rsp_compare,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_a, req_b, req_select, req_mode, req_carry_in,
    output req_ready,
    output rsp_valid, rsp_data, rsp_carry, rsp_compare,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_mp_sequencer.sv
// Multi-precision operation sequencer. Accepts a WORDS x DATA_W operation,
// drives an external combinational ALU one slice per cycle (LSB first),
// chains carry between slices in arithmetic mode and returns the assembled
// result.
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : request/response channels
//   alu_in_a/b      : slice operands to the ALU
//   alu_select/mode : operation controls to the ALU
//   alu_carry_in    : chained carry to the ALU (0 in logic mode)
//   alu_out, alu_carry_out, alu_compare : combinational ALU results
module alu_mp_sequencer #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_mp_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [3:0]        alu_select,
  output logic              alu_mode,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry_out,
  input  logic              alu_compare
);
  import alu_seq_pkg::*;

  localparam int unsigned VEC_W  = WORDS * DATA_W;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned BASE_W = $clog2(VEC_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [VEC_W-1:0]  op_a;
  logic [VEC_W-1:0]  op_b;
  logic [VEC_W-1:0]  result;
  logic [3:0]        sel_q;
  logic              mode_q;
  logic              carry_q;
  logic              cmp_q;
  logic [IDX_W-1:0]  idx;
  logic [BASE_W-1:0] base;
  logic              req_fire;
  logic              last_slice;

  assign req_fire   = (state == IDLE) && bus.req_valid;
  assign last_slice = (idx == LAST_IDX);
  // Bit offset of the active slice, sized to the operand vector.
  assign base       = BASE_W'(idx * DATA_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.req_valid)  state_nxt = RUN;
      RUN:     if (last_slice)     state_nxt = DONE;
      DONE:    if (bus.rsp_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Response and ready are pure state decodes of registered values.
  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.rsp_valid   = (state == DONE);
    bus.rsp_data    = result;
    bus.rsp_carry   = carry_q;
    bus.rsp_compare = cmp_q;
  end

  // ALU drive: zero outside RUN, otherwise the latched controls and the
  // operand slice at idx.
  always_comb begin
    alu_in_a     = '0;
    alu_in_b     = '0;
    alu_select   = '0;
    alu_mode     = 1'b0;
    alu_carry_in = 1'b0;
    if (state == RUN) begin
      alu_in_a     = op_a[base +: DATA_W];
      alu_in_b     = op_b[base +: DATA_W];
      alu_select   = sel_q;
      alu_mode     = mode_q;
      alu_carry_in = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      sel_q   <= '0;
      mode_q  <= MODE_ARITH;
      carry_q <= 1'b0;
      cmp_q   <= 1'b0;
      idx     <= '0;
    end else if (req_fire) begin
      op_a    <= bus.req_a;
      op_b    <= bus.req_b;
      sel_q   <= bus.req_select;
      mode_q  <= bus.req_mode;
      carry_q <= bus.req_carry_in & (bus.req_mode == MODE_ARITH);
      cmp_q   <= 1'b1;
      idx     <= '0;
    end else if (state == RUN) begin
      result[base +: DATA_W] <= alu_out;
      carry_q <= (mode_q == MODE_ARITH) ? alu_carry_out : 1'b0;
      cmp_q   <= cmp_q & alu_compare;
      if (!last_slice) idx <= idx + 1'b1;
    end
  end

endmodule
